// File: rtl/demod_accumulator_pkg.sv
// Shared definitions for the I/Q demodulation accumulator: carrier codes,
// FSM state encoding and the strobe divider lookup.
package demod_accumulator_pkg;

  localparam logic [1:0] freq8MHz = 2'b00;
  localparam logic [1:0] freq4MHz = 2'b01;
  localparam logic [1:0] freq2MHz = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Terminal value of the decimation divider (N-1) for a carrier code.
  function automatic logic [1:0] div_max(input logic [1:0] f);
    logic [1:0] r;
    case (f)
      freq8MHz: r = 2'd0;
      freq4MHz: r = 2'd1;
      default:  r = 2'd3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/demod_channel.sv
// One signed accumulator channel: the sample is sign-extended and either
// loaded or added with a selectable sign.
module demod_channel
  import demod_accumulator_pkg::*;
#(
  parameter int ADC_W = 12,
  parameter int ACC_W = 28
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    load,
  input  logic                    add,
  input  logic                    neg,
  input  logic signed [ADC_W-1:0] sample,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] term;

  always_comb begin
    ext   = {{(ACC_W-ADC_W){sample[ADC_W-1]}}, sample};
    term  = neg ? -ext : ext;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (load) begin
      acc_d = term;
    end else if (add) begin
      acc_d = acc_q + term;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/demod_accumulator.sv
// Square-wave I/Q demodulator: mixes ADC samples at 8 phases per carrier
// period over the DEMOD_ON window and publishes one result per repetition.
module demod_accumulator
  import demod_accumulator_pkg::*;
#(
  parameter int ADC_W = 12,
  parameter int CNT_W = 16,
  parameter int ACC_W = 28
) (
  input  logic                    coreClock,
  input  logic                    RESET_N,
  input  logic [1:0]              freq,
  input  logic                    DEMOD_ON,
  input  logic                    RETRANSMIT,
  input  logic signed [ADC_W-1:0] ADC_DATA,
  output logic signed [ACC_W-1:0] I_OUT,
  output logic signed [ACC_W-1:0] Q_OUT,
  output logic [CNT_W-1:0]        N_OUT,
  output logic                    RESULT_VALID,
  input  logic                    RESULT_READY,
  output logic                    OVERRUN,
  output logic [1:0]              state_dbg
);

  // Result handshake: a result transfers on any cycle with RESULT_VALID and
  // RESULT_READY both high; while RESULT_VALID is high and not accepted the
  // outputs hold. A newer result may overwrite a pending one (OVERRUN).

  state_t                  state_q, state_d;
  logic                    demod_q;
  logic [1:0]              freq_l_q, freq_l_d;
  logic [1:0]              div_q, div_d;
  logic [2:0]              phase_q, phase_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] i_out_q, i_out_d;
  logic signed [ACC_W-1:0] q_out_q, q_out_d;
  logic [CNT_W-1:0]        n_out_q, n_out_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;

  logic                    start;
  logic                    load_res;
  logic                    strobe;
  logic [2:0]              mix_phase;
  logic                    neg_i, neg_q;
  logic                    ch_clr;
  logic signed [ACC_W-1:0] acc_i, acc_q;

  always_comb begin
    start     = DEMOD_ON && !demod_q && (state_q != ST_ACCUM);
    load_res  = (state_q == ST_HOLD) && RETRANSMIT;
    strobe    = (state_q == ST_ACCUM) && DEMOD_ON && (div_q == 2'd0) && !(&cnt_q);
    mix_phase = start ? 3'd0 : phase_q;
    neg_i     = mix_phase[2];
    neg_q     = (mix_phase[2] == mix_phase[1]);
    ch_clr    = load_res && !start;
  end

  always_comb begin
    state_d   = state_q;
    freq_l_d  = freq_l_q;
    div_d     = div_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    i_out_d   = i_out_q;
    q_out_d   = q_out_q;
    n_out_d   = n_out_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;

    case (state_q)
      ST_ACCUM: begin
        if (!DEMOD_ON) begin
          state_d = ST_HOLD;
        end else begin
          div_d = (div_q == div_max(freq_l_q)) ? 2'd0 : div_q + 2'd1;
          if (strobe) begin
            phase_d = phase_q + 3'd1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (RETRANSMIT) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
      end
    endcase

    // The start cycle consumes sample 0, so the counters leave it already
    // advanced; sample k then lands exactly k*N cycles after the start.
    if (start) begin
      state_d  = ST_ACCUM;
      freq_l_d = freq;
      div_d    = (div_max(freq) == 2'd0) ? 2'd0 : 2'd1;
      phase_d  = 3'd1;
      cnt_d    = {{(CNT_W-1){1'b0}}, 1'b1};
      if ((state_q == ST_HOLD) && !RETRANSMIT) begin
        overrun_d = 1'b1;
      end
    end

    if (load_res) begin
      i_out_d = acc_i;
      q_out_d = acc_q;
      n_out_d = cnt_q;
      valid_d = 1'b1;
      if (valid_q && !RESULT_READY) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && RESULT_READY) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge coreClock or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      demod_q   <= 1'b0;
      freq_l_q  <= freq2MHz;
      div_q     <= 2'd0;
      phase_q   <= 3'd0;
      cnt_q     <= '0;
      i_out_q   <= '0;
      q_out_q   <= '0;
      n_out_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      demod_q   <= DEMOD_ON;
      freq_l_q  <= freq_l_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      i_out_q   <= i_out_d;
      q_out_q   <= q_out_d;
      n_out_q   <= n_out_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  demod_channel #(.ADC_W(ADC_W), .ACC_W(ACC_W)) u_chan_i (
    .clk    (coreClock),
    .rst_n  (RESET_N),
    .clr    (ch_clr),
    .load   (start),
    .add    (strobe),
    .neg    (neg_i),
    .sample (ADC_DATA),
    .acc    (acc_i)
  );

  demod_channel #(.ADC_W(ADC_W), .ACC_W(ACC_W)) u_chan_q (
    .clk    (coreClock),
    .rst_n  (RESET_N),
    .clr    (ch_clr),
    .load   (start),
    .add    (strobe),
    .neg    (neg_q),
    .sample (ADC_DATA),
    .acc    (acc_q)
  );

  assign I_OUT        = i_out_q;
  assign Q_OUT        = q_out_q;
  assign N_OUT        = n_out_q;
  assign RESULT_VALID = valid_q;
  assign OVERRUN      = overrun_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_demod_accumulator.sv
// Directed bench for demod_accumulator: hand-computed I/Q sums per carrier,
// handshake/overrun behaviour and asynchronous reset.
module tb_demod_accumulator;
  import demod_accumulator_pkg::*;

  localparam int ADC_W = 12;
  localparam int CNT_W = 16;
  localparam int ACC_W = 28;

  logic                    coreClock;
  logic                    RESET_N;
  logic [1:0]              freq;
  logic                    DEMOD_ON;
  logic                    RETRANSMIT;
  logic signed [ADC_W-1:0] ADC_DATA;
  logic signed [ACC_W-1:0] I_OUT;
  logic signed [ACC_W-1:0] Q_OUT;
  logic [CNT_W-1:0]        N_OUT;
  logic                    RESULT_VALID;
  logic                    RESULT_READY;
  logic                    OVERRUN;
  logic [1:0]              state_dbg;

  int pass_cnt  = 0;
  int total_cnt = 0;

  demod_accumulator #(.ADC_W(ADC_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .coreClock    (coreClock),
    .RESET_N      (RESET_N),
    .freq         (freq),
    .DEMOD_ON     (DEMOD_ON),
    .RETRANSMIT   (RETRANSMIT),
    .ADC_DATA     (ADC_DATA),
    .I_OUT        (I_OUT),
    .Q_OUT        (Q_OUT),
    .N_OUT        (N_OUT),
    .RESULT_VALID (RESULT_VALID),
    .RESULT_READY (RESULT_READY),
    .OVERRUN      (OVERRUN),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial coreClock = 1'b0;
  always #5 coreClock = ~coreClock;

  task automatic tick();
    @(posedge coreClock);
    #1;
  endtask

  // driver: DEMOD_ON high for len cycles; mode 1 is +val for k%8 in 0..3, -val otherwise
  task automatic run_window(input logic [1:0] f, input int len, input int mode,
                            input int val, input int toggle_at, output logic ov_first);
    int v;
    ov_first = 1'b0;
    freq = f;
    for (int k = 0; k < len; k++) begin
      DEMOD_ON = 1'b1;
      if (k == toggle_at) freq = freq8MHz;
      v = (mode == 1 && (k % 8) >= 4) ? -val : val;
      ADC_DATA = v[ADC_W-1:0];
      tick();
      if (k == 0) ov_first = OVERRUN;
    end
    DEMOD_ON = 1'b0;
    ADC_DATA = '0;
    tick();
  endtask

  task automatic pulse_retransmit();
    RETRANSMIT = 1'b1;
    tick();
    RETRANSMIT = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; freq = freq8MHz; DEMOD_ON = 1'b0; RETRANSMIT = 1'b0;
    ADC_DATA = '0; RESULT_READY = 1'b0;
    #12;
    total_cnt++; if (RESULT_VALID !== 1'b0) $display("FAIL reset_valid: got %0b want 0", RESULT_VALID); else pass_cnt++;
    total_cnt++; if (I_OUT !== '0 || Q_OUT !== '0) $display("FAIL reset_iq: got %0d/%0d want 0/0", I_OUT, Q_OUT); else pass_cnt++;
    total_cnt++; if (N_OUT !== '0 || OVERRUN !== 1'b0) $display("FAIL reset_n_ovr: got %0d/%0b want 0/0", N_OUT, OVERRUN); else pass_cnt++;
    total_cnt++; if (state_dbg !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); else pass_cnt++;
    tick();
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_8mhz();
    logic ov;
    run_window(freq8MHz, 8, 1, 100, -1, ov);
    total_cnt++; if (state_dbg !== ST_HOLD) $display("FAIL f8_hold_state: got %0d want %0d", state_dbg, ST_HOLD); else pass_cnt++;
    total_cnt++; if (RESULT_VALID !== 1'b0) $display("FAIL f8_valid_early: got %0b want 0", RESULT_VALID); else pass_cnt++;
    pulse_retransmit();
    total_cnt++; if (RESULT_VALID !== 1'b1) $display("FAIL f8_valid: got %0b want 1", RESULT_VALID); else pass_cnt++;
    total_cnt++; if (I_OUT !== 28'sd800) $display("FAIL f8_i: got %0d want 800", I_OUT); else pass_cnt++;
    total_cnt++; if (Q_OUT !== 28'sd0) $display("FAIL f8_q: got %0d want 0", Q_OUT); else pass_cnt++;
    total_cnt++; if (N_OUT !== 16'd8) $display("FAIL f8_n: got %0d want 8", N_OUT); else pass_cnt++;
    total_cnt++; if (OVERRUN !== 1'b0) $display("FAIL f8_ovr: got %0b want 0", OVERRUN); else pass_cnt++;
    total_cnt++; if (state_dbg !== ST_IDLE) $display("FAIL f8_idle: got %0d want %0d", state_dbg, ST_IDLE); else pass_cnt++;
    RESULT_READY = 1'b1;
    tick();
    RESULT_READY = 1'b0;
    total_cnt++; if (RESULT_VALID !== 1'b0) $display("FAIL f8_accept: got %0b want 0", RESULT_VALID); else pass_cnt++;
  endtask

  task automatic test_4mhz_freq_change();
    logic ov;
    run_window(freq4MHz, 32, 0, -2048, 10, ov);
    pulse_retransmit();
    total_cnt++; if (N_OUT !== 16'd16) $display("FAIL f4_n: got %0d want 16", N_OUT); else pass_cnt++;
    total_cnt++; if (I_OUT !== 28'sd0) $display("FAIL f4_i: got %0d want 0", I_OUT); else pass_cnt++;
    total_cnt++; if (Q_OUT !== 28'sd0) $display("FAIL f4_q: got %0d want 0", Q_OUT); else pass_cnt++;
    RESULT_READY = 1'b1;
    tick();
    RESULT_READY = 1'b0;
  endtask

  task automatic test_2mhz();
    logic ov;
    run_window(freq2MHz, 10, 0, 5, -1, ov);
    pulse_retransmit();
    total_cnt++; if (N_OUT !== 16'd3) $display("FAIL f2_n: got %0d want 3", N_OUT); else pass_cnt++;
    total_cnt++; if (I_OUT !== 28'sd15) $display("FAIL f2_i: got %0d want 15", I_OUT); else pass_cnt++;
    total_cnt++; if (Q_OUT !== -28'sd5) $display("FAIL f2_q: got %0d want -5", Q_OUT); else pass_cnt++;
    total_cnt++; if (RESULT_VALID !== 1'b1) $display("FAIL f2_valid: got %0b want 1", RESULT_VALID); else pass_cnt++;
  endtask

  task automatic test_overrun();
    logic ov;
    // previous 2 MHz result still pending (ready low)
    run_window(freq8MHz, 4, 0, 7, -1, ov);
    total_cnt++; if (I_OUT !== 28'sd15) $display("FAIL ovr_hold_stable: got %0d want 15", I_OUT); else pass_cnt++;
    pulse_retransmit();
    total_cnt++; if (OVERRUN !== 1'b1) $display("FAIL ovr_pulse: got %0b want 1", OVERRUN); else pass_cnt++;
    total_cnt++; if (I_OUT !== 28'sd28 || Q_OUT !== 28'sd0 || N_OUT !== 16'd4)
      $display("FAIL ovr_data: got %0d/%0d/%0d want 28/0/4", I_OUT, Q_OUT, N_OUT); else pass_cnt++;
    tick();
    total_cnt++; if (OVERRUN !== 1'b0) $display("FAIL ovr_one_cycle: got %0b want 0", OVERRUN); else pass_cnt++;
    total_cnt++; if (RESULT_VALID !== 1'b1 || I_OUT !== 28'sd28) $display("FAIL ovr_stable: got %0b/%0d want 1/28", RESULT_VALID, I_OUT); else pass_cnt++;
    // accept on the load cycle: no overrun, new data stays valid
    run_window(freq8MHz, 3, 0, 9, -1, ov);
    RESULT_READY = 1'b1;
    pulse_retransmit();
    total_cnt++; if (OVERRUN !== 1'b0) $display("FAIL acc_load_ovr: got %0b want 0", OVERRUN); else pass_cnt++;
    total_cnt++; if (RESULT_VALID !== 1'b1) $display("FAIL acc_load_valid: got %0b want 1", RESULT_VALID); else pass_cnt++;
    total_cnt++; if (I_OUT !== 28'sd27 || Q_OUT !== -28'sd9 || N_OUT !== 16'd3)
      $display("FAIL acc_load_data: got %0d/%0d/%0d want 27/-9/3", I_OUT, Q_OUT, N_OUT); else pass_cnt++;
    tick();
    total_cnt++; if (RESULT_VALID !== 1'b0) $display("FAIL acc_load_clear: got %0b want 0", RESULT_VALID); else pass_cnt++;
    RESULT_READY = 1'b0;
  endtask

  task automatic test_discard();
    logic ov;
    run_window(freq8MHz, 5, 0, 50, -1, ov);
    run_window(freq2MHz, 10, 0, 5, -1, ov);
    total_cnt++; if (ov !== 1'b1) $display("FAIL disc_ovr: got %0b want 1", ov); else pass_cnt++;
    total_cnt++; if (RESULT_VALID !== 1'b0) $display("FAIL disc_valid: got %0b want 0", RESULT_VALID); else pass_cnt++;
    pulse_retransmit();
    total_cnt++; if (I_OUT !== 28'sd15 || Q_OUT !== -28'sd5 || N_OUT !== 16'd3)
      $display("FAIL disc_data: got %0d/%0d/%0d want 15/-5/3", I_OUT, Q_OUT, N_OUT); else pass_cnt++;
    RESULT_READY = 1'b1;
    tick();
    RESULT_READY = 1'b0;
  endtask

  task automatic test_reset_mid_window();
    logic ov;
    run_window(freq8MHz, 4, 0, 7, -1, ov);
    pulse_retransmit();
    freq = freq8MHz;
    DEMOD_ON = 1'b1;
    ADC_DATA = 12'sd100;
    tick(); tick(); tick();
    #2;
    RESET_N = 1'b0;
    #1;
    total_cnt++; if (I_OUT !== '0 || Q_OUT !== '0 || N_OUT !== '0)
      $display("FAIL rst_mid_data: got %0d/%0d/%0d want 0/0/0", I_OUT, Q_OUT, N_OUT); else pass_cnt++;
    total_cnt++; if (RESULT_VALID !== 1'b0 || state_dbg !== ST_IDLE)
      $display("FAIL rst_mid_ctrl: got %0b/%0d want 0/%0d", RESULT_VALID, state_dbg, ST_IDLE); else pass_cnt++;
    DEMOD_ON = 1'b0;
    ADC_DATA = '0;
    tick();
    RESET_N = 1'b1;
    tick();
    pulse_retransmit();
    tick();
    total_cnt++; if (RESULT_VALID !== 1'b0 || N_OUT !== '0)
      $display("FAIL rst_mid_no_result: got %0b/%0d want 0/0", RESULT_VALID, N_OUT); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_8mhz();
    test_4mhz_freq_change();
    test_2mhz();
    test_overrun();
    test_discard();
    test_reset_mid_window();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
